// File: rtl/hello_scroll_ctrl_if.sv
// Control/status bundle between the scroll sequencer and its driver.
// The sequencer owns sel, chars, tick and state; the driver owns the rest.
interface hello_scroll_ctrl_if ();
   logic        run;
   logic        dir;
   logic        step;
   logic        load;
   logic [14:0] word;
   logic [2:0]  sel;
   logic [14:0] chars;
   logic        tick;
   logic        state;

   modport master (
      output run,
      output dir,
      output step,
      output load,
      output word,
      input  sel,
      input  chars,
      input  tick,
      input  state
   );

   modport slave (
      input  run,
      input  dir,
      input  step,
      input  load,
      input  word,
      output sel,
      output chars,
      output tick,
      output state
   );
endinterface

// File: rtl/hello_scroll_ctrl.sv
// Holds the five-character word and produces the 0..4 rotation select for the
// HEX4..HEX0 character muxes, advancing on a prescaler tick or a button edge.
module hello_scroll_ctrl #(
   parameter int TICK_DIV = 50000000,
   parameter int CNT_W    = 26
) (
   input  logic               CLOCK_50,
   input  logic               Resetn,
   hello_scroll_ctrl_if.slave bus
);

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [14:0]      HELLO_WORD = 15'b000_001_011_011_010;
   localparam logic [2:0]       SEL_MAX    = 3'd4;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       sel_q, sel_d;
   logic [14:0]      chars_q, chars_d;
   logic             tick_q, tick_d;
   logic             step_q, step_d;

   logic             wrap_s;
   logic             step_edge_s;

   // Modulo-5 rotation; an out-of-range select is pulled back to 0.
   function automatic logic [2:0] sel_next(input logic [2:0] cur, input logic down);
      logic [2:0] nxt;
      if (cur > SEL_MAX) begin
         nxt = 3'd0;
      end else if (down) begin
         nxt = (cur == 3'd0) ? SEL_MAX : cur - 3'd1;
      end else begin
         nxt = (cur == SEL_MAX) ? 3'd0 : cur + 3'd1;
      end
      return nxt;
   endfunction

   assign wrap_s      = (state_q == ST_RUN) && (cnt_q >= CNT_LAST);
   assign step_edge_s = bus.step & ~step_q;

   // Next-state logic: load beats an auto advance, which beats a manual step.
   always_comb begin
      state_d = bus.run ? ST_RUN : ST_STOP;
      step_d  = bus.step;
      cnt_d   = '0;
      sel_d   = sel_q;
      chars_d = chars_q;
      tick_d  = 1'b0;

      if (bus.load) begin
         chars_d = bus.word;
         sel_d   = 3'd0;
      end else if (wrap_s) begin
         sel_d  = sel_next(sel_q, bus.dir);
         tick_d = 1'b1;
      end else if ((state_q == ST_STOP) && step_edge_s) begin
         sel_d = sel_next(sel_q, bus.dir);
      end else begin
         sel_d = sel_q;
      end

      if ((state_q == ST_RUN) && !bus.load && !wrap_s) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = '0;
      end
   end

   // State register with synchronous active-low reset; step_q starts high so a
   // button held through reset is not seen as a press.
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state_q <= ST_STOP;
         cnt_q   <= '0;
         sel_q   <= 3'd0;
         chars_q <= HELLO_WORD;
         tick_q  <= 1'b0;
         step_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         chars_q <= chars_d;
         tick_q  <= tick_d;
         step_q  <= step_d;
      end
   end

   assign bus.sel   = sel_q;
   assign bus.chars = chars_q;
   assign bus.tick  = tick_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Directed and randomized bench for hello_scroll_ctrl with TICK_DIV=4, checked
// every cycle against a modulo-arithmetic reference model.
module tb_hello_scroll_ctrl;
   localparam int          TD    = 4;
   localparam logic [14:0] HELLO = 15'b000_001_011_011_010;
   localparam logic [14:0] OLLEH = 15'b010_011_011_001_000;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   hello_scroll_ctrl_if bus ();

   hello_scroll_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
      .CLOCK_50 (clk),
      .Resetn   (rstn),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int          m_state = 0;
   int          m_cnt   = 0;
   int          m_sel   = 0;
   int          m_tick  = 0;
   int          m_stepq = 1;
   logic [14:0] m_chars = HELLO;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Behaviour of one rising edge, from the current inputs.
   task automatic model_edge();
      int   nsel;
      int   ncnt;
      int   ntick;
      logic edge_s;
      if (rstn !== 1'b1) begin
         m_state = 0; m_cnt = 0; m_sel = 0; m_tick = 0; m_stepq = 1;
         m_chars = HELLO;
      end else begin
         edge_s = bus.step && (m_stepq == 0);
         nsel   = m_sel;
         ntick  = 0;
         if (bus.load) begin
            ncnt    = 0;
            nsel    = 0;
            m_chars = bus.word;
         end else if (m_state == 0) begin
            ncnt = 0;
            if (edge_s) nsel = bus.dir ? (m_sel + 4) % 5 : (m_sel + 1) % 5;
         end else begin
            ncnt = (m_cnt + 1) % TD;
            if (m_cnt == TD - 1) begin
               nsel  = bus.dir ? (m_sel + 4) % 5 : (m_sel + 1) % 5;
               ntick = 1;
            end
         end
         m_sel   = nsel;
         m_cnt   = ncnt;
         m_tick  = ntick;
         m_state = bus.run ? 1 : 0;
         m_stepq = bus.step ? 1 : 0;
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      chk("sel",   32'(bus.sel),   32'(m_sel));
      chk("chars", 32'(bus.chars), 32'(m_chars));
      chk("tick",  32'(bus.tick),  32'(m_tick));
      chk("state", 32'(bus.state), 32'(m_state));
      chk("sel_range", 32'(bus.sel <= 3'd4), 32'd1);
   endtask

   initial begin
      int n;
      int ticks;
      int exp_sel;

      bus.run = 1'b0; bus.dir = 1'b0; bus.step = 1'b0; bus.load = 1'b0;
      bus.word = 15'd0;
      rstn = 1'b0;
      repeat (3) cycle();
      chk("reset_sel",   32'(bus.sel),   32'd0);
      chk("reset_chars", 32'(bus.chars), 32'(HELLO));
      chk("reset_state", 32'(bus.state), 32'd0);

      // Auto scroll up: first advance at edge 5, then every 4 edges.
      rstn = 1'b1; bus.run = 1'b1;
      for (int e = 1; e <= 25; e++) begin
         cycle();
         chk("up_sel",  32'(bus.sel),  32'(((e - 1) / 4) % 5));
         chk("up_tick", 32'(bus.tick), 32'((e >= 5) && ((e - 1) % 4 == 0)));
      end

      // Auto scroll down.
      bus.dir = 1'b1;
      repeat (24) cycle();

      // Stopped: clear sel with a load, then three separated step pulses.
      bus.run = 1'b0; bus.dir = 1'b0;
      repeat (2) cycle();
      bus.load = 1'b1; bus.word = HELLO;
      cycle();
      bus.load = 1'b0;
      cycle();
      for (int k = 1; k <= 3; k++) begin
         bus.step = 1'b1;
         cycle();
         chk("step_sel", 32'(bus.sel), 32'(k));
         bus.step = 1'b0;
         repeat (2) cycle();
      end
      bus.step = 1'b1;
      repeat (10) cycle();
      chk("step_held_sel", 32'(bus.sel), 32'd4);
      bus.step = 1'b0;
      cycle();

      // Step pulses in RUN leave the cadence alone.
      bus.run = 1'b1;
      cycle();
      ticks = 0;
      for (int k = 0; k < 20; k++) begin
         bus.step = (k % 3 == 0);
         cycle();
         if (bus.tick === 1'b1) ticks++;
      end
      bus.step = 1'b0;
      chk("run_tick_count", 32'(ticks), 32'd5);

      // Load on a wrap edge with sel=3.
      n = 0;
      while (!(m_state == 1 && m_sel == 3 && m_cnt == 3) && n < 100) begin
         cycle();
         n++;
      end
      chk("wait_load_point", 32'(n < 100), 32'd1);
      bus.load = 1'b1; bus.word = OLLEH;
      cycle();
      bus.load = 1'b0;
      chk("load_chars", 32'(bus.chars), 32'(OLLEH));
      chk("load_sel",   32'(bus.sel),   32'd0);
      chk("load_tick",  32'(bus.tick),  32'd0);
      repeat (3) begin
         cycle();
         chk("post_load_quiet", 32'(bus.tick), 32'd0);
      end
      cycle();
      chk("post_load_tick", 32'(bus.tick), 32'd1);
      chk("post_load_sel",  32'(bus.sel),  32'd1);

      // Button held through reset produces no step.
      bus.step = 1'b1; rstn = 1'b0;
      repeat (2) cycle();
      rstn = 1'b1; bus.run = 1'b0;
      repeat (3) cycle();
      chk("held_step_reset", 32'(bus.sel), 32'd0);
      bus.step = 1'b0;
      cycle();

      // Reset mid-count in RUN with sel=2.
      bus.run = 1'b1;
      n = 0;
      while (!(m_state == 1 && m_sel == 2 && m_cnt == 1) && n < 100) begin
         cycle();
         n++;
      end
      chk("wait_mid_count", 32'(n < 100), 32'd1);
      rstn = 1'b0;
      cycle();
      chk("midrst_sel",   32'(bus.sel),   32'd0);
      chk("midrst_state", 32'(bus.state), 32'd0);
      chk("midrst_tick",  32'(bus.tick),  32'd0);
      chk("midrst_chars", 32'(bus.chars), 32'(HELLO));
      rstn = 1'b1;
      cycle();
      chk("rerun_state", 32'(bus.state), 32'd1);

      // run drops on the wrap edge: one last advance, then hold.
      n = 0;
      while (!(m_state == 1 && m_cnt == 3) && n < 100) begin
         cycle();
         n++;
      end
      chk("wait_wrap", 32'(n < 100), 32'd1);
      exp_sel = (m_sel + 1) % 5;
      bus.run = 1'b0;
      cycle();
      chk("drop_tick",  32'(bus.tick),  32'd1);
      chk("drop_state", 32'(bus.state), 32'd0);
      chk("drop_sel",   32'(bus.sel),   32'(exp_sel));
      repeat (22) begin
         cycle();
         chk("drop_hold", 32'(bus.sel), 32'(exp_sel));
      end

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
         if ($urandom_range(0, 9) == 0) bus.dir = ~bus.dir;
         bus.step = ($urandom_range(0, 3) == 0);
         bus.load = ($urandom_range(0, 29) == 0);
         bus.word = 15'($urandom);
         rstn     = ($urandom_range(0, 99) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
